// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - time-multiplexed 4-digit seven-segment scan driver
//
// Takes the four software-written segment patterns, snapshots them once per
// frame and scans them onto a shared active-low segment bus, one digit at a
// time. Every digit slot opens with a dark guard interval, then an on-window
// whose length follows the brightness setting, then an off remainder.
// Selected digits can blink with a half-period of BLINK_FRAMES frames.
//
// Ports:
//   clk         in   1  system clock
//   reset_n     in   1  asynchronous active-low reset
//   hex0_in..3  in   8  segment patterns, active-low, bit 7 = DP
//   blink_mask  in   4  bit d set makes digit d blink
//   brightness  in   4  on-window = (brightness+1)/16 of the active window
//   seg_n       out  8  shared segment bus, active-low
//   dig_n       out  4  digit enables, active-low, at most one low
//   frame_tick  out  1  one-cycle pulse after the last cycle of each frame

module hex_scan_driver #(
    parameter int STEP_CYCLES  = 3100,
    parameter int BLANK_CYCLES = 400,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] hex0_in,
    input  logic [7:0] hex1_in,
    input  logic [7:0] hex2_in,
    input  logic [7:0] hex3_in,
    input  logic [3:0] blink_mask,
    input  logic [3:0] brightness,
    output logic [7:0] seg_n,
    output logic [3:0] dig_n,
    output logic       frame_tick
);

    localparam int SLOT = BLANK_CYCLES + 16 * STEP_CYCLES;
    localparam int CW   = $clog2(SLOT);
    // One extra code point so the on-window limit can equal SLOT itself.
    localparam int LW   = $clog2(SLOT + 1);
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT - 1);
    localparam logic [LW-1:0] BLANK_L    = LW'(BLANK_CYCLES);
    localparam logic [LW-1:0] STEP_L     = LW'(STEP_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        PH_BLANK,
        PH_ON,
        PH_OFF
    } phase_t;

    // Slot timing state
    logic [CW-1:0] cnt;
    logic [1:0]    d;
    logic [FW-1:0] fc;
    logic          blink_phase;

    // Per-frame and per-slot samples
    logic [7:0]    shadow [4];
    logic [3:0]    br;
    logic          bm;

    // Phase state machine
    phase_t        phase;
    phase_t        phase_nxt;

    // Combinational helpers
    logic          cnt_last;
    logic          frame_end;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    br_nxt;
    logic [LW-1:0] on_limit;
    logic          lit;
    logic [7:0]    seg_nxt;
    logic [3:0]    dig_nxt;

    // ------------------------------------------------------------------
    // Next-state logic. The phase register always describes the current
    // cnt value, so the next phase is derived from the next cnt and the
    // brightness that will be in force then (brightness is captured on the
    // cnt==0 edge, so a slot's first on-cycle already sees the new value
    // even with a one-cycle guard).
    // ------------------------------------------------------------------
    always_comb begin
        cnt_last  = (cnt == SLOT_LAST);
        frame_end = cnt_last && (d == 2'd3);
        cnt_nxt   = cnt_last ? '0 : cnt + CW'(1);
        br_nxt    = (cnt == '0) ? brightness : br;
        on_limit  = BLANK_L + (LW'(br_nxt) + LW'(1)) * STEP_L;

        phase_nxt = PH_OFF;
        if (LW'(cnt_nxt) < BLANK_L) begin
            phase_nxt = PH_BLANK;
        end else if (LW'(cnt_nxt) < on_limit) begin
            phase_nxt = PH_ON;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= PH_BLANK;
        end else begin
            phase <= phase_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: registered, so the bus lags the slot counter by one
    // cycle. A digit blinked dark looks exactly like the off phase.
    // ------------------------------------------------------------------
    always_comb begin
        lit     = (phase == PH_ON) && !(blink_phase && bm);
        seg_nxt = 8'hFF;
        dig_nxt = 4'hF;
        if (lit) begin
            seg_nxt = shadow[d];
            dig_nxt = ~(4'b0001 << d);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_n      <= 8'hFF;
            dig_n      <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= seg_nxt;
            dig_n      <= dig_nxt;
            frame_tick <= frame_end;
        end
    end

    // ------------------------------------------------------------------
    // Slot counter and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            d   <= 2'd0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt_last) begin
                d <= d + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink frame counter. The phase flips when the counter wraps, which
    // happens on the same edge as the frame-end pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fc          <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (fc == FRAME_LAST) begin
                fc          <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fc <= fc + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshots. Patterns are taken only at the start of a frame so a
    // software update never tears across digits; brightness and the
    // digit's blink bit are taken at the start of each slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow[0] <= 8'hFF;
            shadow[1] <= 8'hFF;
            shadow[2] <= 8'hFF;
            shadow[3] <= 8'hFF;
            br        <= 4'd0;
            bm        <= 1'b0;
        end else if (cnt == '0) begin
            br <= brightness;
            bm <= blink_mask[d];
            if (d == 2'd0) begin
                shadow[0] <= hex0_in;
                shadow[1] <= hex1_in;
                shadow[2] <= hex2_in;
                shadow[3] <= hex3_in;
            end
        end
    end

endmodule
